// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared definitions for the RV32I MEM stage. This package holds
//               the load/store funct3 codes, the MEM-stage FSM state type, and
//               store-lane and alignment helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mem_state_e;

  // Byte enables for a store. Any code other than SB/SH is a word store.
  function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_SB:   store_be = 4'b0001 << addr;
      F3_SH:   store_be = 4'b0011 << {addr[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte enables alone select the target.
  function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_SB:   store_wdata = {4{data[7:0]}};
      F3_SH:   store_wdata = {2{data[15:0]}};
      default: store_wdata = data;
    endcase
  endfunction

  // Byte accesses are never misaligned. Halves need addr[0]==0, and words need addr[1:0]==0.
  function automatic logic access_misaligned(input logic is_store, input logic [2:0] funct3,
                                             input logic [1:0] addr);
    logic is_byte;
    logic is_half;
    if (is_store) begin
      is_byte = (funct3 == F3_SB);
      is_half = (funct3 == F3_SH);
    end else begin
      is_byte = (funct3 == F3_LB) || (funct3 == F3_LBU);
      is_half = (funct3 == F3_LH) || (funct3 == F3_LHU);
    end
    if (is_byte)      access_misaligned = 1'b0;
    else if (is_half) access_misaligned = addr[0];
    else              access_misaligned = (addr != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_load_formatter.sv
`default_nettype none
// ============================================================================
// Module      : load_formatter
// Description : Combinational load-data formatter. This block selects a byte,
//               a halfword or the full word from the read data, and then sign-
//               or zero-extends the result to 32 bits.
// Ports       : funct3 - load size/sign code
//               addr   - low address bits selecting the lane
//               rdata  - raw word from data memory
//               result - extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{addr, 3'b000} +: 8];
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  result = {24'b0, w_byte};
      F3_LH:   result = {{16{w_half[15]}}, w_half};
      F3_LHU:  result = {16'b0, w_half};
      default: result = rdata;   // LW and unused codes read the whole word
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the 5-stage RV32I pipeline. It issues loads and
//               stores over a req/ack data bus, stalls the pipeline while a
//               transfer is outstanding, and formats the load data.
//               Non-memory instructions pass through combinationally.
// Ports       : clk, rst_n, flush         - clock, async active-low reset, squash
//               ex_*                      - EX/MEM register contents
//               mem_stall                 - hold upstream pipeline registers
//               dmem_req/we/addr/wdata/be - registered bus request
//               dmem_ack/rdata            - bus completion and read word
//               mem_*                     - results towards mem_writeback_pipe
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32   // RV32 only: four byte lanes
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [4:0]            ex_reg_dest,
  input  logic                  ex_reg_write,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_alu_result,
  output logic [DATA_WIDTH-1:0] mem_mem_data,
  output logic [4:0]            mem_reg_dest,
  output logic                  mem_reg_write,
  output logic                  mem_misaligned
);

  mem_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic [2:0]            r_funct3;
  logic                  r_is_load;

  logic                  w_memop;
  logic                  w_misaligned_addr;
  logic                  w_misaligned;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_fmt_data;

  assign w_memop           = ex_valid & (ex_mem_read | ex_mem_write);
  // When read and write are both set, the store wins. This also selects which alignment table applies.
  assign w_misaligned_addr = access_misaligned(ex_mem_write, ex_funct3, ex_alu_result[1:0]);
  assign w_misaligned      = (r_state == IDLE) & w_memop & w_misaligned_addr;
  assign w_accept          = (r_state == IDLE) & w_memop & ~w_misaligned_addr & ~flush;

  // The formatter works on the captured funct3/address because ack can arrive many cycles later.
  load_formatter u_load_formatter (
    .funct3 (r_funct3),
    .addr   (r_addr[1:0]),
    .rdata  (dmem_rdata),
    .result (w_fmt_data)
  );

  always_comb begin
    mem_stall      = 1'b0;
    mem_valid      = 1'b0;
    mem_alu_result = ex_alu_result;
    mem_mem_data   = '0;
    mem_misaligned = 1'b0;
    case (r_state)
      IDLE: begin
        // Pass-through for non-memops. A misaligned access completes here with a trap flag.
        mem_stall      = w_accept;
        mem_valid      = ex_valid & ~flush & ~w_accept;
        mem_misaligned = w_misaligned & ~flush;
      end
      WAIT, DRAIN: begin
        mem_stall = 1'b1;
      end
      DONE: begin
        // EX/MEM still holds the same instruction, so rd and the write flags come from ex_*.
        mem_valid      = ~flush;
        mem_mem_data   = r_load_data;
        mem_alu_result = r_addr;
      end
      default: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  assign mem_reg_dest  = ex_reg_dest;
  assign mem_reg_write = ex_reg_write & ~ex_mem_write & ~w_misaligned & mem_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
      r_addr      <= '0;
      r_funct3    <= '0;
      r_is_load   <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= {ex_alu_result[DATA_WIDTH-1:2], 2'b00};
            dmem_wdata <= ex_mem_write ? store_wdata(ex_funct3, ex_store_data) : '0;
            dmem_be    <= ex_mem_write ? store_be(ex_funct3, ex_alu_result[1:0]) : 4'b1111;
            r_addr     <= ex_alu_result;
            r_funct3   <= ex_funct3;
            r_is_load  <= ~ex_mem_write;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            r_load_data <= r_is_load ? w_fmt_data : '0;
            // A flush that coincides with ack has nothing left to drain.
            r_state     <= flush ? IDLE : DONE;
          end else if (flush) begin
            // The bus has no cancel, so the stage waits out the transfer and discards it.
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            r_state  <= IDLE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. It runs a vector
//               table, a flush-during-WAIT sequence and a mid-transfer reset
//               sequence. A variable-latency memory model drives the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [4:0]  ex_reg_dest = '0;
  logic        ex_reg_write = 1'b0;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_mem_data;
  logic [4:0]  mem_reg_dest;
  logic        mem_reg_write;
  logic        mem_misaligned;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_funct3      (ex_funct3),
    .ex_reg_dest    (ex_reg_dest),
    .ex_reg_write   (ex_reg_write),
    .mem_stall      (mem_stall),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .mem_valid      (mem_valid),
    .mem_alu_result (mem_alu_result),
    .mem_mem_data   (mem_mem_data),
    .mem_reg_dest   (mem_reg_dest),
    .mem_reg_write  (mem_reg_write),
    .mem_misaligned (mem_misaligned)
  );

  // Memory model: ack arrives in the ack_lat-th cycle that req is high. Read data is valid only with ack.
  int unsigned ack_lat = 1;
  logic [31:0] rd_word = '0;
  int unsigned req_cnt;
  assign dmem_ack   = dmem_req && (req_cnt == ack_lat - 1);
  assign dmem_rdata = dmem_ack ? rd_word : 32'hA5A5_A5A5;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        req_cnt <= 0;
    else if (dmem_ack) req_cnt <= 0;
    else if (dmem_req) req_cnt <= req_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard of expected mem_valid beats
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && mem_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'b0, mem_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mem_mem_data", mem_mem_data, e.data);
        chk("mem_alu_result", mem_alu_result, e.alu);
        chk("mem_reg_dest", {27'b0, mem_reg_dest}, {27'b0, e.rd});
        chk("mem_reg_write", {31'b0, mem_reg_write}, {31'b0, e.rw});
        chk("mem_misaligned", {31'b0, mem_misaligned}, {31'b0, e.mis});
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rword;
    logic [4:0]  rdst;
    logic        rw;
    logic        fl;
    int          lat;
    logic        ev;       // expect a mem_valid beat
    logic [31:0] e_data;
    logic        e_rw;
    logic        e_mis;
    int          e_stall;  // cycles with mem_stall high
    logic        e_req;    // a bus request is issued
    logic        e_we;
    logic [3:0]  e_be;     // checked for stores only
    logic [31:0] e_wdata;  // checked for stores only
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic drive(input vec_t v);
    ex_valid      = 1'b1;
    ex_mem_read   = v.rd;
    ex_mem_write  = v.wr;
    ex_funct3     = v.f3;
    ex_alu_result = v.addr;
    ex_store_data = v.sdata;
    ex_reg_dest   = v.rdst;
    ex_reg_write  = v.rw;
    flush         = v.fl;
  endtask

  task automatic idle_inputs();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          stalls;
    logic        done;
    logic        seen_req;
    logic        c_we;
    logic [3:0]  c_be;
    logic [31:0] c_wdata;
    logic [31:0] c_addr;
    exp_t        e;
    stalls = 0; done = 1'b0; seen_req = 1'b0;
    c_we = 1'b0; c_be = '0; c_wdata = '0; c_addr = '0;
    ack_lat = v.lat;
    rd_word = v.rword;
    if (v.ev) begin
      e = '{alu: v.addr, data: v.e_data, rd: v.rdst, rw: v.e_rw, mis: v.e_mis};
      sb.push_back(e);
    end
    @(posedge clk); #1;
    drive(v);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (dmem_req && !seen_req) begin
        seen_req = 1'b1;
        c_we = dmem_we; c_be = dmem_be; c_wdata = dmem_wdata; c_addr = dmem_addr;
      end
      if (mem_stall) stalls++;
      else           done = 1'b1;
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    $display("vector %0d: stall cycles %0d", idx, stalls);
    chk("stall_cycles", 32'(stalls), 32'(v.e_stall));
    chk("req_issued", {31'b0, seen_req}, {31'b0, v.e_req});
    chk("req_released", {31'b0, dmem_req}, 32'd0);
    if (v.e_req) begin
      chk("dmem_we", {31'b0, c_we}, {31'b0, v.e_we});
      chk("dmem_addr", c_addr, {v.addr[31:2], 2'b00});
      if (v.wr) begin
        chk("dmem_be", {28'b0, c_be}, {28'b0, v.e_be});
        chk("dmem_wdata", c_wdata, v.e_wdata);
      end
    end
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  vec_t add_v;

  initial begin
    //            rd   wr   f3      addr          sdata         rword         rdst  rw  fl  lat  ev  e_data        e_rw e_mis st  req we  be      wdata
    vecs[0]  = '{1'b0,1'b0,3'b000,32'h1234_5678,32'h0,        32'h0,        5'd3, 1'b1,1'b0,1, 1'b1,32'h0000_0000,1'b1,1'b0,0, 1'b0,1'b0,4'h0, 32'h0};
    vecs[1]  = '{1'b1,1'b0,3'b010,32'h0000_0100,32'h0,        32'hDEAD_BEEF,5'd1, 1'b1,1'b0,2, 1'b1,32'hDEAD_BEEF,1'b1,1'b0,3, 1'b1,1'b0,4'h0, 32'h0};
    vecs[2]  = '{1'b1,1'b0,3'b000,32'h0000_0103,32'h0,        32'h8012_3456,5'd2, 1'b1,1'b0,1, 1'b1,32'hFFFF_FF80,1'b1,1'b0,2, 1'b1,1'b0,4'h0, 32'h0};
    vecs[3]  = '{1'b1,1'b0,3'b100,32'h0000_0103,32'h0,        32'h8012_3456,5'd4, 1'b1,1'b0,1, 1'b1,32'h0000_0080,1'b1,1'b0,2, 1'b1,1'b0,4'h0, 32'h0};
    vecs[4]  = '{1'b1,1'b0,3'b001,32'h0000_0102,32'h0,        32'h8001_7FFF,5'd5, 1'b1,1'b0,1, 1'b1,32'hFFFF_8001,1'b1,1'b0,2, 1'b1,1'b0,4'h0, 32'h0};
    vecs[5]  = '{1'b1,1'b0,3'b101,32'h0000_0100,32'h0,        32'h8001_F00D,5'd6, 1'b1,1'b0,1, 1'b1,32'h0000_F00D,1'b1,1'b0,2, 1'b1,1'b0,4'h0, 32'h0};
    vecs[6]  = '{1'b1,1'b0,3'b000,32'h0000_0101,32'h0,        32'h1122_3344,5'd7, 1'b1,1'b0,1, 1'b1,32'h0000_0033,1'b1,1'b0,2, 1'b1,1'b0,4'h0, 32'h0};
    vecs[7]  = '{1'b0,1'b1,3'b001,32'h0000_0102,32'h1234_ABCD,32'h0,        5'd8, 1'b1,1'b0,1, 1'b1,32'h0000_0000,1'b0,1'b0,2, 1'b1,1'b1,4'hC, 32'hABCD_ABCD};
    vecs[8]  = '{1'b0,1'b1,3'b000,32'h0000_0201,32'h0000_00EF,32'h0,        5'd9, 1'b0,1'b0,3, 1'b1,32'h0000_0000,1'b0,1'b0,4, 1'b1,1'b1,4'h2, 32'hEFEF_EFEF};
    vecs[9]  = '{1'b0,1'b1,3'b010,32'h0000_0204,32'hCAFE_F00D,32'h0,        5'd10,1'b0,1'b0,1, 1'b1,32'h0000_0000,1'b0,1'b0,2, 1'b1,1'b1,4'hF, 32'hCAFE_F00D};
    vecs[10] = '{1'b1,1'b0,3'b010,32'h0000_0101,32'h0,        32'h0,        5'd11,1'b1,1'b0,1, 1'b1,32'h0000_0000,1'b0,1'b1,0, 1'b0,1'b0,4'h0, 32'h0};
    vecs[11] = '{1'b0,1'b1,3'b001,32'h0000_0103,32'h0,        32'h0,        5'd12,1'b0,1'b0,1, 1'b1,32'h0000_0000,1'b0,1'b1,0, 1'b0,1'b0,4'h0, 32'h0};
    vecs[12] = '{1'b0,1'b0,3'b000,32'h0000_0042,32'h0,        32'h0,        5'd13,1'b1,1'b1,1, 1'b0,32'h0000_0000,1'b0,1'b0,0, 1'b0,1'b0,4'h0, 32'h0};
    vecs[13] = '{1'b1,1'b0,3'b010,32'h0000_0100,32'h0,        32'h0,        5'd14,1'b1,1'b1,1, 1'b0,32'h0000_0000,1'b0,1'b0,0, 1'b0,1'b0,4'h0, 32'h0};
    vecs[14] = '{1'b1,1'b0,3'b011,32'h0000_0108,32'h0,        32'h0102_0304,5'd15,1'b1,1'b0,2, 1'b1,32'h0102_0304,1'b1,1'b0,3, 1'b1,1'b0,4'h0, 32'h0};
    vecs[15] = '{1'b1,1'b1,3'b010,32'h0000_010C,32'h55AA_55AA,32'h0,        5'd16,1'b1,1'b0,1, 1'b1,32'h0000_0000,1'b0,1'b0,2, 1'b1,1'b1,4'hF, 32'h55AA_55AA};
    add_v = vecs[0];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_dmem_be", {28'b0, dmem_be}, 32'd0);
    chk("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Flush during WAIT. The transfer drains until ack, and no result is produced.
    begin
      int   n_drain;
      logic acked;
      logic stall_low;
      vec_t ld;
      exp_t e;
      n_drain = 0; acked = 1'b0; stall_low = 1'b0;
      ld = vecs[1];
      ack_lat = 5;
      rd_word = 32'h1357_2468;
      @(posedge clk); #1;
      drive(ld);
      @(negedge clk);
      chk("fw_accept_stall", {31'b0, mem_stall}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("fw_wait_stall", {31'b0, mem_stall}, 32'd1);
      @(posedge clk); #1;
      idle_inputs();
      for (int c = 0; c < 20 && !acked; c++) begin
        @(negedge clk);
        n_drain++;
        if (!mem_stall) stall_low = 1'b1;
        if (dmem_ack) acked = 1'b1;
      end
      chk("fw_drain_acked", {31'b0, acked}, 32'd1);
      chk("fw_drain_cycles", 32'(n_drain), 32'd4);
      chk("fw_drain_stall_low", {31'b0, stall_low}, 32'd0);
      e = '{alu: add_v.addr, data: 32'h0, rd: add_v.rdst, rw: 1'b1, mis: 1'b0};
      sb.push_back(e);
      @(posedge clk); #1;
      drive(add_v);
      @(negedge clk);
      chk("fw_next_stall", {31'b0, mem_stall}, 32'd0);
      chk("fw_next_req", {31'b0, dmem_req}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("fw_sb_drained", sb.size(), 32'd0);
    end

    // Reset asserted in the middle of WAIT
    ack_lat = 10;
    rd_word = 32'h0BAD_F00D;
    @(posedge clk); #1;
    drive(vecs[1]);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_req_before", {31'b0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("mr_req_async", {31'b0, dmem_req}, 32'd0);
    chk("mr_we", {31'b0, dmem_we}, 32'd0);
    chk("mr_addr", dmem_addr, 32'd0);
    chk("mr_be", {28'b0, dmem_be}, 32'd0);
    chk("mr_stall", {31'b0, mem_stall}, 32'd0);
    chk("mr_valid", {31'b0, mem_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(100, add_v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
